// File: rtl/pc_stack_reg.sv
// Program-counter register with a DEPTH-entry circular return-address stack.
// Optional target alignment check is enabled by defining PC_ALIGN_CHK_EN.
module pc_stack_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       STEP      = 4,
  parameter int unsigned       DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     ras_depth,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_ovf,
  output logic                       err
);

  localparam int unsigned      PW      = $clog2(DEPTH);
  localparam int unsigned      DW      = PW + 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_RSV6   = 3'b110,
    OP_RSV7   = 3'b111
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    sp_q, sp_d;      // next slot to write; top entry is sp_q-1
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push;
  logic [WIDTH-1:0] target;
  logic             misaligned;
  logic [PW-1:0]    top_idx;

  assign top_idx = sp_q - 1'b1;

  always_comb begin
    case (op_e'(op))
      OP_BRANCH:        target = pc_q + data_in;
      OP_JUMP, OP_CALL: target = data_in;
      default:          target = pc_q;
    endcase
  end

`ifdef PC_ALIGN_CHK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - 1'b1;
  assign misaligned = |(target & ALIGN_MASK);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (ena) begin
      case (op_e'(op))
        OP_HOLD: ;
        OP_INC:  pc_d = pc_q + STEP_W;
        OP_BRANCH, OP_JUMP: begin
          if (misaligned) err_d = 1'b1;
          else            pc_d  = target;
        end
        OP_CALL: begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = target;
            sp_d = sp_q + 1'b1;
            if (depth_q == DEPTH_W) ovf_d   = 1'b1;
            else                    depth_d = depth_q + 1'b1;
          end
        end
        OP_RET: begin
          if (depth_q == '0) begin
            err_d = 1'b1;
          end else begin
            pc_d    = mem_q[top_idx];
            sp_d    = top_idx;
            depth_d = depth_q - 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // NOTE: stack storage is not reset; depth_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[sp_q] <= pc_q + STEP_W;
  end

  assign data_out  = pc_q;
  assign ras_depth = depth_q;
  assign ras_empty = (depth_q == '0);
  assign ras_full  = (depth_q == DEPTH_W);
  assign ras_ovf   = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pc_stack_reg.sv
// Self-checking bench for pc_stack_reg: directed sequences with literal expectations
// plus randomized ops compared each cycle against a queue-based behavioural model.
module tb_pc_stack_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, BRANCH = 3'd2, JUMP = 3'd3,
                         CALL = 3'd4, RET = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [2:0]  ras_depth;
  logic        ras_empty, ras_full, ras_ovf, err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  pc_stack_reg #(.WIDTH(WIDTH), .RESET_VEC(RVEC), .STEP(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .op(op), .data_in(data_in),
    .data_out(data_out), .ras_depth(ras_depth), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_ovf, m_err;

  function automatic bit is_misaligned(input logic [31:0] t);
`ifdef PC_ALIGN_CHK_EN
    return (t % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = RVEC; m_stk.delete(); m_ovf = 0; m_err = 0;
    end else begin
      logic [31:0] t;
      m_err = 0;
      if (ena) begin
        case (op)
          HOLD: ;
          INC:  m_pc = m_pc + 32'd4;
          BRANCH, JUMP: begin
            t = (op == BRANCH) ? m_pc + data_in : data_in;
            if (is_misaligned(t)) m_err = 1; else m_pc = t;
          end
          CALL: begin
            if (is_misaligned(data_in)) m_err = 1;
            else begin
              if (m_stk.size() == DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1;
              end
              m_stk.push_back(m_pc + 32'd4);
              m_pc = data_in;
            end
          end
          RET: begin
            if (m_stk.size() == 0) m_err = 1;
            else m_pc = m_stk.pop_back();
          end
          default: m_err = 1;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pc",    64'(data_out),  64'(m_pc));
      check("m_depth", 64'(ras_depth), 64'(m_stk.size()));
      check("m_empty", 64'(ras_empty), 64'(m_stk.size() == 0));
      check("m_full",  64'(ras_full),  64'(m_stk.size() == DEPTH));
      check("m_ovf",   64'(ras_ovf),   64'(m_ovf));
      check("m_err",   64'(err),       64'(m_err));
    end
  end

  task automatic step(input logic e, input logic [2:0] o, input logic [31:0] d);
    @(negedge clk);
    ena = e; op = o; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; op = HOLD; data_in = '0;
    #12;
    check("rst_pc",    64'(data_out),  64'(RVEC));
    check("rst_depth", 64'(ras_depth), 64'd0);
    check("rst_empty", 64'(ras_empty), 64'd1);
    check("rst_full",  64'(ras_full),  64'd0);
    check("rst_ovf",   64'(ras_ovf),   64'd0);
    check("rst_err",   64'(err),       64'd0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    step(1, INC, 0); check("inc1", 64'(data_out), 64'h4);
    step(1, INC, 0); check("inc2", 64'(data_out), 64'h8);
    step(1, INC, 0); check("inc3", 64'(data_out), 64'hC);
    check("inc_empty", 64'(ras_empty), 64'd1);
    check("inc_err",   64'(err),       64'd0);

    step(0, JUMP, 32'h5A5A5A58); check("ena0_hold", 64'(data_out), 64'hC);
    step(1, JUMP, 32'h5A5A5A58); check("jump",      64'(data_out), 64'h5A5A5A58);

    step(1, JUMP, 32'h100);
    step(1, BRANCH, 32'hFFFF_FFF0); check("branch_neg", 64'(data_out), 64'hF0);
    step(1, JUMP, 32'hFFFF_FFFC);
    step(1, INC, 0);                check("inc_wrap",   64'(data_out), 64'h0);

    step(1, JUMP, 32'h10);
    step(1, CALL, 32'h200); check("call1_pc", 64'(data_out), 64'h200); check("call1_d", 64'(ras_depth), 64'd1);
    step(1, CALL, 32'h300); check("call2_pc", 64'(data_out), 64'h300); check("call2_d", 64'(ras_depth), 64'd2);
    step(1, RET, 0);        check("ret1_pc",  64'(data_out), 64'h204); check("ret1_d",  64'(ras_depth), 64'd1);
    step(1, RET, 0);        check("ret2_pc",  64'(data_out), 64'h14);  check("ret2_d",  64'(ras_depth), 64'd0);

    for (int i = 1; i <= 5; i++) step(1, CALL, 32'(i) << 12);
    check("ovf_full",  64'(ras_full),  64'd1);
    check("ovf_flag",  64'(ras_ovf),   64'd1);
    check("ovf_depth", 64'(ras_depth), 64'd4);
    step(1, RET, 0); check("pop1", 64'(data_out), 64'h4004);
    step(1, RET, 0); check("pop2", 64'(data_out), 64'h3004);
    step(1, RET, 0); check("pop3", 64'(data_out), 64'h2004);
    step(1, RET, 0); check("pop4", 64'(data_out), 64'h1004);
    step(1, RET, 0); check("pop_empty_err", 64'(err), 64'd1); check("pop_empty_pc", 64'(data_out), 64'h1004);
    step(1, HOLD, 0); check("err_pulse_end", 64'(err), 64'd0);
    check("ovf_sticky", 64'(ras_ovf), 64'd1);

    step(1, 3'd6, 0); check("rsv_err", 64'(err), 64'd1); check("rsv_pc", 64'(data_out), 64'h1004);
    step(1, 3'd7, 0); check("rsv7_err", 64'(err), 64'd1);

    step(1, JUMP, 32'h1000);
    step(1, JUMP, 32'h1236);
`ifdef PC_ALIGN_CHK_EN
    check("align_pc",  64'(data_out), 64'h1000);
    check("align_err", 64'(err),      64'd1);
`else
    check("align_pc",  64'(data_out), 64'h1236);
    check("align_err", 64'(err),      64'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      d = $urandom();
      if ($urandom_range(0, 3) != 0) d = d & 32'h0000_FFFC;
      step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), d);
    end

    for (int i = 0; i < 5; i++) step(1, CALL, 32'h8000);
    @(negedge clk);
    ena = 1'b1; op = CALL; data_in = 32'h9000;
    #2 rst = 1'b0;
    #1;
    check("midrst_pc",    64'(data_out),  64'(RVEC));
    check("midrst_depth", 64'(ras_depth), 64'd0);
    check("midrst_ovf",   64'(ras_ovf),   64'd0);
    check("midrst_empty", 64'(ras_empty), 64'd1);
    @(posedge clk); #1;
    check("midrst_hold", 64'(data_out), 64'(RVEC));
    @(negedge clk);
    rst = 1'b1; ena = 1'b0;
    step(1, INC, 0); check("post_rst_inc", 64'(data_out), 64'h4);
    @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
